sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
Digital sequencer that drives the set/reset inputs of the analog SR latch and reads its q/qb outputs back. It accepts one command at a time over a valid/ready handshake, produces a single clean non-overlapping set or reset pulse of programmable width, and waits a fixed settle time. It then samples the synchronised latch outputs and returns a response with status flags. The block sits in the digital section of the tile; s_drv/r_drv route to the latch s/r pins, and the latch q/qb pins route back to q_in/qb_in.

Parameters:
CNT_W, 8, width of the pulse-length and settle counters.
SETTLE_CYC, 4, cycles between pulse end and sample. Minimum 2; covers the synchroniser latency.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
cmd_valid  input  1  command offered.
cmd_ready  output  1  block can accept a command; high only in IDLE.
cmd_op  input  2  00 READ, 01 SET, 10 RESET, 11 ILLEGAL.
pulse_len  input  CNT_W  pulse width in cycles, captured at accept; 0 is treated as 1.
s_drv  output  1  set drive to the latch.
r_drv  output  1  reset drive to the latch.
q_in  input  1  latch q; asynchronous to clk.
qb_in  input  1  latch qb; asynchronous to clk.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer accepts the response.
rsp_q  output  1  sampled synchronised q.
rsp_err  output  3  bit0 invalid latch state, bit1 mismatch with expected value, bit2 illegal opcode.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Single clock; all flops update on the rising edge of clk; rst is synchronous and active-high.
- Reset values:
  - state=IDLE, cmd_ready=1, s_drv=0, r_drv=0.
  - rsp_valid=0, rsp_q=0, rsp_err=000, busy=0.
  - counters=0, synchroniser flops=0.
- Input synchronisation: q_in and qb_in each pass through a 2-flop synchroniser, giving q_s and qb_s.
- States: IDLE, PULSE, SETTLE, SAMPLE, RESP.
- IDLE:
  - Accept when cmd_valid && cmd_ready. On accept, latch op and len=max(pulse_len,1).
  - Next state is PULSE for SET/RESET, SETTLE for READ/ILLEGAL.
- PULSE:
  - s_drv=1 for SET, r_drv=1 for RESET; both outputs are registered.
  - The drive stays high for exactly len cycles, counted by a down-counter.
  - Then go to SETTLE with both drives low.
- SETTLE: both drives low for exactly SETTLE_CYC cycles, then SAMPLE.
- SAMPLE (1 cycle):
  - rsp_q <= q_s.
  - err0 = (q_s == qb_s).
  - err1 = op SET and q_s != 1, or op RESET and q_s != 0; always 0 for READ/ILLEGAL.
  - err2 = (op == ILLEGAL).
  - Next state RESP.
- RESP:
  - rsp_valid=1; rsp_q and rsp_err are held stable.
  - On rsp_valid && rsp_ready, clear rsp_valid and return to IDLE. cmd_ready rises on the following cycle; there is no back-to-back bypass.
- Latency: accept at edge 0. The pulse occupies cycles 1..len and SETTLE the next SETTLE_CYC cycles. SAMPLE is at 1+len+SETTLE_CYC and rsp_valid rises at 2+len+SETTLE_CYC. READ has the same timing with len=0.
- Invariants:
  - s_drv && r_drv is never 1.
  - No drive is asserted outside PULSE.
  - ILLEGAL never drives either line.
- pulse_len changes after accept are ignored.
- A command offered while busy is not accepted (cmd_ready=0); the initiator holds it.
- rst in any state, including mid-pulse: the drives are low from the next edge; any pending response is discarded; the block is in IDLE with cmd_ready=1.
- Counters never wrap: len max is 2^CNT_W-1 and is counted down to 1.

Decomposition:
- Package sr_latch_pkg:
  - opcode localparams OP_READ/OP_SET/OP_RESET/OP_ILLEGAL;
  - state enum;
  - rsp_err bit indices ERR_INVALID=0, ERR_MISMATCH=1, ERR_OPCODE=2.
- Sub-module sync_2ff: parameterised width, reset to 0; one instance for {q_in, qb_in}.

Test Plan:
- SET, pulse_len=3, SETTLE_CYC=4, q_in=1/qb_in=0 modelled after the pulse:
  - s_drv high for exactly cycles 1-3, r_drv 0 throughout;
  - rsp_valid at cycle 9 with rsp_q=1, rsp_err=000.
- RESET, pulse_len=0, latch model responding:
  - r_drv high for exactly 1 cycle;
  - rsp_valid at cycle 7 with rsp_q=0, rsp_err=000.
- SET with latch model stuck q=0, qb=1:
  - rsp_q=0, rsp_err=010.
- READ with q_in=qb_in=1, then ILLEGAL:
  - READ: no drive pulses, rsp_err=001.
  - ILLEGAL: no drive pulses, rsp_err=100 (plus 001 if q==qb).
- Backpressure: hold rsp_ready=0 for 10 cycles while offering a second cmd_valid:
  - rsp fields stay stable, cmd_ready stays 0;
  - after handshake, the second command is accepted one cycle later.
- Assert rst in the 2nd cycle of a pulse_len=5 SET:
  - s_drv=0 on the next edge, no rsp_valid, cmd_ready=1, busy=0.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg
// Shared definitions for the SR latch driver: command opcodes, sequencer
// states, response error bit positions and the response error calculation.
package sr_latch_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_SET     = 2'b01;
    localparam logic [1:0] OP_RESET   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Bit positions inside rsp_err
    localparam logic [1:0] ERR_INVALID  = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_OPCODE   = 2'd2;

    // Status flags for a sampled latch: q==qb is never a legal latch state,
    // and only SET/RESET carry an expected value to compare against.
    function automatic logic [2:0] calc_err(input logic [1:0] op,
                                            input logic       q,
                                            input logic       qb);
        logic [2:0] err;
        err               = 3'b000;
        err[ERR_INVALID]  = (q == qb);
        err[ERR_MISMATCH] = ((op == OP_SET)   && (q != 1'b1)) ||
                            ((op == OP_RESET) && (q != 1'b0));
        err[ERR_OPCODE]   = (op == OP_ILLEGAL);
        return err;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for signals asynchronous to clk.
// Ports: clk, rst (sync, active-high, clears both stages),
//        d (asynchronous input), q (synchronised output, 2-cycle latency).
module sync_2ff #(
    parameter int unsigned WIDTH = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture; the first stage may go metastable and is never used directly
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
// Sequencer that drives the set/reset pins of an analog SR latch with one
// clean pulse per command, waits for the latch to settle, samples the
// synchronised q/qb and returns a response with status flags.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_op, pulse_len              opcode and pulse width (0 acts as 1)
//   s_drv, r_drv                   registered drives to latch s/r
//   q_in, qb_in                    latch outputs, asynchronous to clk
//   rsp_valid/rsp_ready            response handshake
//   rsp_q, rsp_err                 sampled q and {opcode, mismatch, invalid}
//   busy                           high outside IDLE
module sr_latch_driver
    import sr_latch_pkg::*;
#(
    parameter int unsigned CNT_W      = 32'd8,
    parameter int unsigned SETTLE_CYC = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] pulse_len,
    output logic             s_drv,
    output logic             r_drv,
    input  logic             q_in,
    input  logic             qb_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_q,
    output logic [2:0]       rsp_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);

    state_t           state_r,     state_nx_s;
    logic [CNT_W-1:0] cnt_r,       cnt_nx_s;
    logic [1:0]       op_r,        op_nx_s;
    logic             s_drv_r,     s_drv_nx_s;
    logic             r_drv_r,     r_drv_nx_s;
    logic             rsp_valid_r, rsp_valid_nx_s;
    logic             rsp_q_r,     rsp_q_nx_s;
    logic [2:0]       rsp_err_r,   rsp_err_nx_s;
    logic             cmd_ready_r, cmd_ready_nx_s;
    logic             busy_r,      busy_nx_s;
    logic [1:0]       sync_s;
    logic             q_s;
    logic             qb_s;

    sync_2ff #(
        .WIDTH (32'd2)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({q_in, qb_in}),
        .q   (sync_s)
    );

    assign q_s  = sync_s[1];
    assign qb_s = sync_s[0];

    // Next-state, counter and registered-output decode
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        op_nx_s        = op_r;
        s_drv_nx_s     = 1'b0;
        r_drv_nx_s     = 1'b0;
        rsp_valid_nx_s = rsp_valid_r;
        rsp_q_nx_s     = rsp_q_r;
        rsp_err_nx_s   = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    op_nx_s = cmd_op;
                    if ((cmd_op == OP_SET) || (cmd_op == OP_RESET)) begin
                        state_nx_s = ST_PULSE;
                        cnt_nx_s   = (pulse_len == CNT_ZERO) ? CNT_ONE : pulse_len;
                        // Drive is raised on the accept edge so it is high from cycle 1
                        s_drv_nx_s = (cmd_op == OP_SET);
                        r_drv_nx_s = (cmd_op == OP_RESET);
                    end else begin
                        state_nx_s = ST_SETTLE;
                        cnt_nx_s   = SETTLE_LOAD;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_SETTLE;
                    cnt_nx_s   = SETTLE_LOAD;
                end else begin
                    cnt_nx_s   = cnt_r - CNT_ONE;
                    s_drv_nx_s = (op_r == OP_SET);
                    r_drv_nx_s = (op_r == OP_RESET);
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_SAMPLE;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    cnt_nx_s   = cnt_r - CNT_ONE;
                end
            end
            ST_SAMPLE: begin
                state_nx_s     = ST_RESP;
                rsp_valid_nx_s = 1'b1;
                rsp_q_nx_s     = q_s;
                rsp_err_nx_s   = calc_err(op_r, q_s, qb_s);
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx_s     = ST_IDLE;
                    rsp_valid_nx_s = 1'b0;
                end else begin
                    state_nx_s     = ST_RESP;
                end
            end
            default: begin
                state_nx_s     = ST_IDLE;
                cnt_nx_s       = CNT_ZERO;
                rsp_valid_nx_s = 1'b0;
            end
        endcase
        // Handshake flags follow the next state so they are registered too
        cmd_ready_nx_s = (state_nx_s == ST_IDLE);
        busy_nx_s      = (state_nx_s != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            op_r        <= OP_READ;
            s_drv_r     <= 1'b0;
            r_drv_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_q_r     <= 1'b0;
            rsp_err_r   <= 3'b000;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            op_r        <= op_nx_s;
            s_drv_r     <= s_drv_nx_s;
            r_drv_r     <= r_drv_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
            rsp_q_r     <= rsp_q_nx_s;
            rsp_err_r   <= rsp_err_nx_s;
            cmd_ready_r <= cmd_ready_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    assign s_drv     = s_drv_r;
    assign r_drv     = r_drv_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_q     = rsp_q_r;
    assign rsp_err   = rsp_err_r;
    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver
// Directed and randomised bench for sr_latch_driver with a behavioural latch
// model and a transaction-level expectation of drive windows and responses.
module tb_sr_latch_driver;

    localparam int CNT_W      = 8;
    localparam int SETTLE_CYC = 4;

    localparam logic [1:0] T_READ    = 2'b00;
    localparam logic [1:0] T_SET     = 2'b01;
    localparam logic [1:0] T_RESET   = 2'b10;
    localparam logic [1:0] T_ILLEGAL = 2'b11;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] pulse_len;
    logic             s_drv;
    logic             r_drv;
    logic             q_in;
    logic             qb_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_q;
    logic [2:0]       rsp_err;
    logic             busy;

    int errors = 0;
    int checks = 0;
    logic live;

    sr_latch_driver #(
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .pulse_len (pulse_len),
        .s_drv     (s_drv),
        .r_drv     (r_drv),
        .q_in      (q_in),
        .qb_in     (qb_in),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_err(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Analog latch: s sets, r resets; stuck when not live
    task automatic latch_update();
        if (live) begin
            if (s_drv && !r_drv) begin
                q_in  = 1'b1;
                qb_in = 1'b0;
            end else if (r_drv && !s_drv) begin
                q_in  = 1'b0;
                qb_in = 1'b1;
            end
        end
    endtask

    // Runs one command starting at a negedge in IDLE; ends at the negedge after the response handshake.
    task automatic run_cmd(input logic [1:0] op, input int len, input int hold,
                           input logic offer_next, input logic [1:0] next_op, input int next_len);
        int eff;
        int rsp_cyc;
        logic exp_q;
        logic mism;
        logic [2:0] exp_err;
        eff     = ((op == T_SET) || (op == T_RESET)) ? ((len == 0) ? 1 : len) : 0;
        rsp_cyc = 2 + eff + SETTLE_CYC;
        check_bit("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        pulse_len = len[CNT_W-1:0];
        @(posedge clk);
        for (int cyc = 1; cyc <= rsp_cyc; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            pulse_len = CNT_W'($urandom);
            check_bit("s_drv_window", s_drv, (op == T_SET) && (cyc <= eff));
            check_bit("r_drv_window", r_drv, (op == T_RESET) && (cyc <= eff));
            check_bit("rsp_valid_timing", rsp_valid, cyc == rsp_cyc);
            check_bit("cmd_ready_busy", cmd_ready, 1'b0);
            check_bit("busy_high", busy, 1'b1);
            latch_update();
        end
        exp_q   = q_in;
        mism    = ((op == T_SET) && (q_in !== 1'b1)) || ((op == T_RESET) && (q_in !== 1'b0));
        exp_err = {op == T_ILLEGAL, mism, q_in == qb_in};
        check_bit("rsp_q", rsp_q, exp_q);
        check_err("rsp_err", rsp_err, exp_err);
        if (offer_next) begin
            cmd_valid = 1'b1;
            cmd_op    = next_op;
            pulse_len = next_len[CNT_W-1:0];
        end
        rsp_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_bit("hold_rsp_valid", rsp_valid, 1'b1);
            check_bit("hold_rsp_q", rsp_q, exp_q);
            check_err("hold_rsp_err", rsp_err, exp_err);
            check_bit("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_bit("post_rsp_valid", rsp_valid, 1'b0);
        check_bit("post_cmd_ready", cmd_ready, 1'b1);
        check_bit("post_busy", busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = T_READ;
        pulse_len = '0;
        rsp_ready = 1'b0;
        q_in      = 1'b0;
        qb_in     = 1'b1;
        live      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_bit("rst_cmd_ready", cmd_ready, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_s_drv", s_drv, 1'b0);
        check_bit("rst_r_drv", r_drv, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        check_bit("rst_rsp_q", rsp_q, 1'b0);
        check_err("rst_rsp_err", rsp_err, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // SET len 3 on a responsive latch
        run_cmd(T_SET, 3, 0, 1'b0, T_READ, 0);
        // RESET len 0 behaves as len 1
        run_cmd(T_RESET, 0, 0, 1'b0, T_READ, 0);
        // Stuck latch q=0/qb=1 does not follow SET
        live = 1'b0; q_in = 1'b0; qb_in = 1'b1;
        run_cmd(T_SET, 2, 1, 1'b0, T_READ, 0);
        // READ of an invalid latch state
        q_in = 1'b1; qb_in = 1'b1;
        run_cmd(T_READ, 5, 0, 1'b0, T_READ, 0);
        // ILLEGAL opcode, invalid then valid latch state
        run_cmd(T_ILLEGAL, 4, 0, 1'b0, T_READ, 0);
        q_in = 1'b0; qb_in = 1'b1;
        run_cmd(T_ILLEGAL, 0, 2, 1'b0, T_READ, 0);
        // Backpressure with a second command waiting, accepted right after the handshake
        live = 1'b1;
        run_cmd(T_SET, 1, 10, 1'b1, T_RESET, 2);
        run_cmd(T_RESET, 2, 0, 1'b0, T_READ, 0);
        // Longest pulse
        run_cmd(T_SET, 255, 0, 1'b0, T_READ, 0);

        // Reset in the 2nd cycle of a len-5 SET pulse
        cmd_valid = 1'b1;
        cmd_op    = T_SET;
        pulse_len = 8'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_bit("rstmid_s_cycle1", s_drv, 1'b1);
        @(negedge clk);
        check_bit("rstmid_s_cycle2", s_drv, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_bit("rstmid_s_drv", s_drv, 1'b0);
        check_bit("rstmid_rsp_valid", rsp_valid, 1'b0);
        check_bit("rstmid_cmd_ready", cmd_ready, 1'b1);
        check_bit("rstmid_busy", busy, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_bit("rstmid_quiet_s", s_drv, 1'b0);
            check_bit("rstmid_quiet_rsp", rsp_valid, 1'b0);
            check_bit("rstmid_quiet_ready", cmd_ready, 1'b1);
        end

        // Randomised commands and latch behaviour
        for (int n = 0; n < 25; n++) begin
            logic [1:0] rop;
            int rlen;
            rop  = 2'($urandom_range(0, 3));
            rlen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            live = 1'($urandom_range(0, 1));
            if (!live) begin
                q_in  = 1'($urandom_range(0, 1));
                qb_in = 1'($urandom_range(0, 1));
            end
            run_cmd(rop, rlen, int'($urandom_range(0, 3)), 1'b0, T_READ, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
